// File: rtl/ttc_tx.sv
// rtl/ttc_tx.sv - TTC link serial transmitter: sync burst after reset/resync, then FIFO words or idle fill
module ttc_tx #(
   parameter logic [15:0] SYNC_WORD   = 16'h817E,
   parameter logic [15:0] IDLE_WORD   = 16'h817E,
   parameter int unsigned SYNC_FRAMES = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk160,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        resync,
   output logic        full,
   output logic        overflow,
   output logic        sync_done,
   output logic        frame_start,
   output logic        dataout
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [7:0]    FRAMES_C = 8'(SYNC_FRAMES);

   typedef enum logic {S_SYNC = 1'b0, S_RUN = 1'b1} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_bit_cnt;
   logic [15:0]   r_shreg;
   logic [7:0]    r_sync_cnt;
   logic          r_resync_req;
   logic          r_overflow;
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_load;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_req_clr;
   logic [15:0]   w_word;
   logic [7:0]    w_sync_cnt_nxt;

   // full/empty both look at the pre-edge count, so a pop never frees room for a same-edge write
   assign w_load  = (r_bit_cnt == 4'd15);
   assign w_full  = (r_count == DEPTH_C);
   assign w_empty = (r_count == '0);
   assign w_push  = wr_en && !w_full;

   always_ff @(posedge clk160) begin
      if (rst) begin
         r_state <= S_SYNC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_load) begin
         if (r_resync_req) begin
            w_state_nxt = S_SYNC;
         end else if (r_state == S_SYNC && r_sync_cnt == FRAMES_C) begin
            w_state_nxt = S_RUN;
         end
      end
   end

   always_comb begin
      w_word         = SYNC_WORD;
      w_pop          = 1'b0;
      w_req_clr      = 1'b0;
      w_sync_cnt_nxt = r_sync_cnt;
      if (w_load) begin
         if (r_resync_req) begin
            w_sync_cnt_nxt = 8'd1;
            w_req_clr      = 1'b1;
         end else if (r_state == S_SYNC && r_sync_cnt != FRAMES_C) begin
            w_sync_cnt_nxt = r_sync_cnt + 8'd1;
         end else begin
            w_pop  = !w_empty;
            w_word = w_empty ? IDLE_WORD : r_mem[r_rd_ptr];
         end
      end
   end

   always_ff @(posedge clk160) begin
      if (rst) begin
         r_bit_cnt    <= 4'd15;
         r_shreg      <= '0;
         r_sync_cnt   <= '0;
         r_resync_req <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_bit_cnt    <= r_bit_cnt + 4'd1;
         r_shreg      <= w_load ? w_word : {r_shreg[14:0], 1'b0};
         r_sync_cnt   <= w_sync_cnt_nxt;
         r_resync_req <= resync || (r_resync_req && !w_req_clr);
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk160) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk160) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   assign dataout     = r_shreg[15];
   assign frame_start = (r_bit_cnt == 4'd0);
   assign sync_done   = (r_state == S_RUN);
   assign full        = w_full;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_ttc_tx.sv
// tb/tb_ttc_tx.sv - self-checking bench for ttc_tx: frame-level reference model plus directed and random scenarios
`timescale 1ns/1ps
module tb_ttc_tx;
   localparam logic [15:0] SYNC_W = 16'h817E;
   localparam logic [15:0] IDLE_W = 16'h817E;
   localparam int          NFR    = 16;
   localparam int          DEPTH  = 4;

   logic        clk160 = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        resync = 1'b0;
   logic        full;
   logic        overflow;
   logic        sync_done;
   logic        frame_start;
   logic        dataout;

   ttc_tx #(
      .SYNC_WORD  (SYNC_W),
      .IDLE_WORD  (IDLE_W),
      .SYNC_FRAMES(NFR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk160     (clk160),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .resync     (resync),
      .full       (full),
      .overflow   (overflow),
      .sync_done  (sync_done),
      .frame_start(frame_start),
      .dataout    (dataout)
   );

   always #3 clk160 = ~clk160;

   int n_vec = 0;
   int n_err = 0;
   int gcyc  = 0;

   // Reference: current frame word held whole, bit position within frame, burst frame count, FIFO as queue
   int          m_pos   = 15;
   logic [15:0] m_word  = '0;
   bit          m_run   = 0;
   int          m_burst = 0;
   bit          m_pend  = 0;
   bit          m_ovf   = 0;
   logic [15:0] m_q [$];

   logic [15:0] rx_words [$];
   logic [15:0] rx_acc = '0;
   int          rx_n   = 0;

   task automatic tick();
      bit ld, full_b, empty_b, old_pend;
      @(posedge clk160);
      ld       = (m_pos == 15);
      full_b   = (m_q.size() == DEPTH);
      empty_b  = (m_q.size() == 0);
      old_pend = m_pend;
      if (rst) begin
         m_pos = 15; m_word = '0; m_run = 0; m_burst = 0; m_pend = 0; m_ovf = 0;
         m_q.delete();
      end else begin
         if (ld) begin
            if (old_pend) begin
               m_run = 0; m_burst = 1; m_word = SYNC_W;
            end else if (!m_run && m_burst < NFR) begin
               m_burst++; m_word = SYNC_W;
            end else begin
               m_run = 1;
               if (empty_b) m_word = IDLE_W;
               else         m_word = m_q.pop_front();
            end
         end
         m_pend = resync || (old_pend && !ld);
         if (wr_en) begin
            if (full_b) m_ovf = 1;
            else        m_q.push_back(wr_data);
         end
         m_pos = (m_pos + 1) % 16;
      end
      gcyc++;
      @(negedge clk160);
      n_vec++;
      if (dataout !== m_word[15 - m_pos]) begin
         n_err++; $display("FAIL model_dataout cyc %0d: got %b want %b", gcyc, dataout, m_word[15 - m_pos]);
      end
      n_vec++;
      if (frame_start !== (m_pos == 0)) begin
         n_err++; $display("FAIL model_frame_start cyc %0d: got %b want %b", gcyc, frame_start, m_pos == 0);
      end
      n_vec++;
      if (sync_done !== m_run) begin
         n_err++; $display("FAIL model_sync_done cyc %0d: got %b want %b", gcyc, sync_done, m_run);
      end
      n_vec++;
      if (full !== (m_q.size() == DEPTH)) begin
         n_err++; $display("FAIL model_full cyc %0d: got %b want %b", gcyc, full, m_q.size() == DEPTH);
      end
      n_vec++;
      if (overflow !== m_ovf) begin
         n_err++; $display("FAIL model_overflow cyc %0d: got %b want %b", gcyc, overflow, m_ovf);
      end
      // recover whole frames from the wire for word-level checks
      if (rst) begin
         rx_n = 0;
      end else if (frame_start) begin
         rx_acc = {15'd0, dataout}; rx_n = 1;
      end else if (rx_n > 0) begin
         rx_acc = {rx_acc[14:0], dataout}; rx_n++;
         if (rx_n == 16) begin
            rx_words.push_back(rx_acc); rx_n = 0;
         end
      end
   endtask

   task automatic wait_pos(input int p);
      for (int i = 0; i < 16 && m_pos != p; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1; wr_en = 0; resync = 0; wr_data = '0;
      for (int i = 0; i < 4; i++) tick();
      n_vec++;
      if ({dataout, frame_start, sync_done, full, overflow} !== 5'b0) begin
         n_err++; $display("FAIL reset_outputs: got %b want 00000", {dataout, frame_start, sync_done, full, overflow});
      end
   endtask

   task automatic test_sync_burst();
      int t0 = -1;
      int t1 = -1;
      int prev_fs, nfs;
      rx_words.delete();
      rst = 0;
      for (int i = 0; i < 400 && t1 < 0; i++) begin
         tick();
         if (i == 0) begin
            n_vec++;
            if (frame_start !== 1'b1 || dataout !== 1'b1) begin
               n_err++; $display("FAIL first_edge: got fs=%b do=%b want fs=1 do=1", frame_start, dataout);
            end
         end
         if (frame_start && t0 < 0) t0 = gcyc;
         if (sync_done && t1 < 0) t1 = gcyc;
      end
      n_vec++;
      if (t0 < 0 || t1 < 0 || (t1 - t0) != NFR * 16) begin
         n_err++; $display("FAIL run_entry: got %0d cycles want %0d", t1 - t0, NFR * 16);
      end
      n_vec++;
      if (rx_words.size() != NFR) begin
         n_err++; $display("FAIL sync_frame_count: got %0d want %0d", rx_words.size(), NFR);
      end
      for (int i = 0; i < NFR && i < rx_words.size(); i++) begin
         n_vec++;
         if (rx_words[i] !== SYNC_W) begin
            n_err++; $display("FAIL sync_word[%0d]: got %h want %h", i, rx_words[i], SYNC_W);
         end
      end
      prev_fs = t1; nfs = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (frame_start) begin
            n_vec++;
            if (gcyc - prev_fs != 16) begin
               n_err++; $display("FAIL fs_period: got %0d want 16", gcyc - prev_fs);
            end
            prev_fs = gcyc; nfs++;
         end
      end
      n_vec++;
      if (nfs != 4) begin
         n_err++; $display("FAIL fs_count: got %0d want 4", nfs);
      end
   endtask

   task automatic test_single_word();
      logic [15:0] exp_w [$] = '{IDLE_W, 16'hF0F0, IDLE_W};
      int n, wc;
      int fs = -1;
      wait_pos(12);
      n = rx_words.size(); wc = gcyc;
      wr_en = 1; wr_data = 16'hF0F0;
      tick();
      wr_en = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (frame_start && fs < 0) fs = gcyc;
      end
      n_vec++;
      if (fs - wc != 4) begin
         n_err++; $display("FAIL write_latency: got %0d want 4", fs - wc);
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         n_vec++;
         if (n + i >= rx_words.size() || rx_words[n + i] !== exp_w[i]) begin
            n_err++; $display("FAIL single_word[%0d]: got %h want %h", i,
                              (n + i < rx_words.size()) ? rx_words[n + i] : 16'hxxxx, exp_w[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_w [$] = '{IDLE_W, 16'hF0F0, 16'hF0F1, 16'hF0F2, 16'hF0F3, IDLE_W};
      int n;
      wait_pos(0);
      n = rx_words.size();
      for (int k = 0; k < 5; k++) begin
         wr_en = 1; wr_data = 16'hF0F0 + 16'(k);
         tick();
      end
      wr_en = 0;
      n_vec++;
      if (overflow !== 1'b1 || full !== 1'b1) begin
         n_err++; $display("FAIL b2b_flags: got ovf=%b full=%b want ovf=1 full=1", overflow, full);
      end
      wait_pos(15);
      n_vec++;
      if (full !== 1'b1) begin
         n_err++; $display("FAIL b2b_full_before_pop: got %b want 1", full);
      end
      tick();
      n_vec++;
      if (full !== 1'b0) begin
         n_err++; $display("FAIL b2b_full_after_pop: got %b want 0", full);
      end
      for (int i = 0; i < 5 * 16; i++) tick();
      for (int i = 0; i < exp_w.size(); i++) begin
         n_vec++;
         if (n + i >= rx_words.size() || rx_words[n + i] !== exp_w[i]) begin
            n_err++; $display("FAIL b2b_word[%0d]: got %h want %h", i,
                              (n + i < rx_words.size()) ? rx_words[n + i] : 16'hxxxx, exp_w[i]);
         end
      end
   endtask

   task automatic test_resync();
      int n;
      int low = 0;
      wait_pos(0);
      wr_en = 1; wr_data = 16'hA1A1; tick();
      wr_data = 16'hB2B2; tick();
      wr_en = 0;
      wait_pos(7);
      n = rx_words.size();
      resync = 1; tick(); resync = 0;
      if (!sync_done) low++;
      for (int i = 0; i < 19 * 16 - 1; i++) begin
         tick();
         if (!sync_done) low++;
      end
      n_vec++;
      if (low != NFR * 16) begin
         n_err++; $display("FAIL resync_low_cycles: got %0d want %0d", low, NFR * 16);
      end
      for (int i = 0; i < 19; i++) begin
         logic [15:0] e;
         e = (i == 17) ? 16'hA1A1 : (i == 18) ? 16'hB2B2 : SYNC_W;
         n_vec++;
         if (n + i >= rx_words.size() || rx_words[n + i] !== e) begin
            n_err++; $display("FAIL resync_word[%0d]: got %h want %h", i,
                              (n + i < rx_words.size()) ? rx_words[n + i] : 16'hxxxx, e);
         end
      end
   endtask

   task automatic wait_run(input string tag);
      bit ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         tick();
         ok = sync_done;
      end
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL %s_run_timeout: got sync_done=0 want 1", tag);
      end
   endtask

   task automatic test_collision();
      logic [15:0] exp_w [$] = '{IDLE_W, 16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3, 16'hD1D1, 16'hD2D2, IDLE_W};
      int n;
      rst = 1; tick(); tick(); tick(); rst = 0;
      wait_run("coll");
      wait_pos(0);
      n = rx_words.size();
      for (int k = 0; k < 4; k++) begin
         wr_en = 1; wr_data = 16'hC0C0 + 16'h0101 * 16'(k);
         tick();
      end
      wr_en = 0;
      n_vec++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         n_err++; $display("FAIL coll_fill: got full=%b ovf=%b want full=1 ovf=0", full, overflow);
      end
      wait_pos(15);
      wr_en = 1; wr_data = 16'hD0D0; tick(); wr_en = 0;
      n_vec++;
      if (overflow !== 1'b1 || full !== 1'b0) begin
         n_err++; $display("FAIL coll_full_edge: got ovf=%b full=%b want ovf=1 full=0", overflow, full);
      end
      wait_pos(15);
      wr_en = 1; wr_data = 16'hD1D1; tick();
      n_vec++;
      if (full !== 1'b0) begin
         n_err++; $display("FAIL coll_count3_edge: got full=%b want 0", full);
      end
      wr_data = 16'hD2D2; tick(); wr_en = 0;
      n_vec++;
      if (full !== 1'b1) begin
         n_err++; $display("FAIL coll_refill: got full=%b want 1", full);
      end
      for (int i = 0; i < 8 * 16; i++) tick();
      for (int i = 0; i < exp_w.size(); i++) begin
         n_vec++;
         if (n + i >= rx_words.size() || rx_words[n + i] !== exp_w[i]) begin
            n_err++; $display("FAIL coll_word[%0d]: got %h want %h", i,
                              (n + i < rx_words.size()) ? rx_words[n + i] : 16'hxxxx, exp_w[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      wait_pos(0);
      wr_en = 1; wr_data = 16'hE5A5; tick();
      wr_data = 16'h1234; tick();
      wr_data = 16'h5678; tick();
      wr_en = 0;
      wait_pos(0);
      wait_pos(7);
      rst = 1; tick();
      n_vec++;
      if (dataout !== 1'b0 || sync_done !== 1'b0 || full !== 1'b0) begin
         n_err++; $display("FAIL rst_mid: got do=%b sd=%b full=%b want 0 0 0", dataout, sync_done, full);
      end
      tick(); rst = 0;
      rx_words.delete();
      wait_run("rstmid");
      n_vec++;
      if (rx_words.size() != NFR) begin
         n_err++; $display("FAIL rst_mid_burst: got %0d frames want %0d", rx_words.size(), NFR);
      end
      n = rx_words.size();
      for (int i = 0; i < 40; i++) tick();
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (n + i >= rx_words.size() || rx_words[n + i] !== IDLE_W) begin
            n_err++; $display("FAIL rst_mid_fifo_empty[%0d]: got %h want %h", i,
                              (n + i < rx_words.size()) ? rx_words[n + i] : 16'hxxxx, IDLE_W);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_data = 16'($urandom);
         resync  = ($urandom_range(0, 199) == 0);
         rst     = ($urandom_range(0, 1499) == 0);
         tick();
      end
      wr_en = 0; resync = 0; rst = 0;
      for (int i = 0; i < 32; i++) tick();
   endtask

   initial begin
      test_reset();
      test_sync_burst();
      test_single_word();
      test_back_to_back();
      test_resync();
      test_collision();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
